// File: rtl/kamacore_pkg.sv
// Shared types and constants for the kamacore pipeline stages.
package kamacore_pkg;

    localparam int CPU_WIDTH = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]          insn;
        logic [CPU_WIDTH-1:0] pc;
    } fetch_entry_t;

    function automatic logic [CPU_WIDTH-1:0] align_word(input logic [CPU_WIDTH-1:0] addr);
        return {addr[CPU_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/kamacore_pipeline_stage_if.sv
// Pipeline register bundle between two stages; the upstream stage is the master.
interface kamacore_pipeline_stage;
    import kamacore_pkg::*;

    logic [31:0]          instruction;
    logic [CPU_WIDTH-1:0] pc;
    logic                 valid;

    modport master (output instruction, output pc, output valid);
    modport slave  (input  instruction, input  pc, input  valid);

endinterface

// File: rtl/kamacore_fetch_fifo.sv
// Small synchronous FIFO of fetched words; flush wins over push and pop.
module kamacore_fetch_fifo
    import kamacore_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             pop_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty    = (count == '0);
    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/kamacore_stage_if.sv
// Instruction Fetch stage: owns the PC, issues credit-limited word fetches and feeds ID.
module kamacore_stage_if
    import kamacore_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC   = '0,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    kamacore_pipeline_stage.master pipeline_if_id
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CPU_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0] rsp_pc;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        drop_cnt;
    logic [CW-1:0]        fifo_count;
    logic [CW:0]          in_use;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 issue;
    logic                 dropping;
    logic                 push;
    logic                 pop;
    fetch_entry_t         push_entry;
    fetch_entry_t         head_entry;

    logic [31:0]          out_insn;
    logic [CPU_WIDTH-1:0] out_pc;
    logic                 out_valid;

    // Credits cover both buffered words and words still in flight, so the FIFO can never overflow.
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = rst & ~redirect_valid & (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign issue          = imem_req_valid & imem_req_ready;
    assign dropping       = (drop_cnt != '0);
    assign push           = imem_rsp_valid & ~dropping & ~redirect_valid;
    assign pop            = ~redirect_valid & ~stall & ~fifo_empty;
    assign push_entry     = '{insn: imem_rsp_data, pc: rsp_pc};

    kamacore_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // rsp_pc is the address of the next live response; responses come back in order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({issue, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (redirect_valid) begin
                pc       <= align_word(redirect_pc);
                rsp_pc   <= align_word(redirect_pc);
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (issue)                     pc       <= pc + CPU_WIDTH'(4);
                if (push)                      rsp_pc   <= rsp_pc + CPU_WIDTH'(4);
                if (imem_rsp_valid && dropping) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_insn  <= NOP_INSN;
            out_pc    <= '0;
            out_valid <= 1'b0;
        end else if (redirect_valid || (!stall && fifo_empty)) begin
            out_insn  <= NOP_INSN;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_insn  <= head_entry.insn;
            out_pc    <= head_entry.pc;
            out_valid <= 1'b1;
        end
    end

    assign pipeline_if_id.instruction = out_insn;
    assign pipeline_if_id.pc          = out_pc;
    assign pipeline_if_id.valid       = out_valid;

endmodule

// File: tb/tb_kamacore_stage_if.sv
// Self-checking bench for kamacore_stage_if: directed vector table, hand sequences and random traffic.
module tb_kamacore_stage_if;
    import kamacore_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    kamacore_pipeline_stage id_if ();

    kamacore_stage_if #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pipeline_if_id (id_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          dead;
    } flight_t;

    typedef struct {
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    // Reference model: words in flight (also the memory's pending queue) and the buffered words.
    flight_t      inflight[$];
    fetch_entry_t mfifo[$];
    logic [31:0]  m_pc;
    logic [31:0]  m_out_insn;
    logic [31:0]  m_out_pc;
    bit           m_out_valid;

    int   checks   = 0;
    int   failures = 0;
    bit   check_en = 1'b0;
    bit   vec_active = 1'b0;
    vec_t cur_vec;
    vec_t vecs[9];

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input bit r, input bit rdr);
        bit m_req;
        m_req = r && !rdr && (inflight.size() + mfifo.size() < DEPTH);
        checkVal("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
        if (m_req) checkVal("req_addr", imem_req_addr, m_pc);
        checkVal("id_valid", {31'b0, id_if.valid}, {31'b0, m_out_valid});
        checkVal("id_pc", id_if.pc, m_out_pc);
        checkVal("id_insn", id_if.instruction, m_out_insn);
        if (vec_active) begin
            checkVal("vec_req_valid", {31'b0, imem_req_valid}, {31'b0, cur_vec.exp_req});
            if (cur_vec.exp_req) checkVal("vec_req_addr", imem_req_addr, cur_vec.exp_addr);
            checkVal("vec_id_valid", {31'b0, id_if.valid}, {31'b0, cur_vec.exp_valid});
            checkVal("vec_id_pc", id_if.pc, cur_vec.exp_pc);
        end
    endtask

    task automatic modelUpdate(input bit r, input bit rdy, input bit rsp_v, input logic [31:0] rsp_d,
                               input bit stl, input bit rdr, input logic [31:0] rpc);
        bit      req;
        bit      hs;
        bit      have;
        flight_t f;
        req  = r && !rdr && (inflight.size() + mfifo.size() < DEPTH);
        hs   = req && rdy;
        have = 1'b0;
        if (!r) begin
            inflight.delete();
            mfifo.delete();
            m_pc        = RESET_PC;
            m_out_insn  = NOP_INSN;
            m_out_pc    = '0;
            m_out_valid = 1'b0;
        end else begin
            if (rsp_v) begin
                f    = inflight.pop_front();
                have = 1'b1;
            end
            if (rdr) begin
                mfifo.delete();
                foreach (inflight[i]) inflight[i].dead = 1'b1;
                m_out_valid = 1'b0;
                m_out_insn  = NOP_INSN;
                m_pc        = {rpc[31:2], 2'b00};
            end else begin
                if (!stl) begin
                    if (mfifo.size() > 0) begin
                        m_out_insn  = mfifo[0].insn;
                        m_out_pc    = mfifo[0].pc;
                        m_out_valid = 1'b1;
                        void'(mfifo.pop_front());
                    end else begin
                        m_out_insn  = NOP_INSN;
                        m_out_valid = 1'b0;
                    end
                end
                if (have && !f.dead) mfifo.push_back('{insn: rsp_d, pc: f.addr});
                if (hs) begin
                    inflight.push_back('{addr: m_pc, dead: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // One clock cycle: drive at posedge+1, check at the negedge, advance the model at the posedge.
    task automatic applyStimulus(input bit r, input bit rdy, input bit rsp_en, input bit stl,
                                 input bit rdr, input logic [31:0] rpc);
        bit          rsp_v;
        logic [31:0] rsp_d;
        rsp_v = r && rsp_en && (inflight.size() > 0);
        rsp_d = rsp_v ? memData(inflight[0].addr) : 32'hDEAD_BEEF;
        rst            = r;
        imem_req_ready = rdy;
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_d;
        stall          = stl;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        #4;
        if (check_en) checkOutput(r, rdr);
        @(posedge clk);
        modelUpdate(r, rdy, rsp_v, rsp_d, stl, rdr, rpc);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        bit found;

        // Streaming from reset with an always-ready, one-cycle memory; credits allow two words in use.
        vecs[0] = '{1, 1, 32'h00, 0, 32'h0};
        vecs[1] = '{1, 1, 32'h04, 0, 32'h0};
        vecs[2] = '{1, 0, 32'h08, 0, 32'h0};
        vecs[3] = '{1, 1, 32'h08, 1, 32'h0};
        vecs[4] = '{1, 1, 32'h0C, 1, 32'h4};
        vecs[5] = '{1, 0, 32'h10, 0, 32'h4};
        vecs[6] = '{1, 1, 32'h10, 1, 32'h8};
        vecs[7] = '{1, 1, 32'h14, 1, 32'hC};
        vecs[8] = '{1, 0, 32'h18, 0, 32'hC};

        m_pc = RESET_PC; m_out_insn = NOP_INSN; m_out_pc = '0; m_out_valid = 1'b0;
        rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        @(posedge clk);
        #1;

        applyStimulus(0, 1, 1, 0, 0, 0);
        check_en = 1'b1;
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            cur_vec    = vecs[i];
            vec_active = 1'b1;
            applyStimulus(1, vecs[i].ready, 1, 0, 0, 0);
        end
        vec_active = 1'b0;

        // Memory not ready: address must hold, ID sees bubbles.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 0, 0);

        // ID stall while memory keeps streaming.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, 0, 0);

        // Redirect with two words in flight; both must be dropped.
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        checkVal("two_in_flight", inflight.size(), 2);
        applyStimulus(1, 1, 0, 0, 1, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0);
            if (id_if.valid === 1'b1) found = 1'b1;
        end
        checkVal("redirect_found", {31'b0, found}, 32'd1);
        checkVal("redirect_first_pc", id_if.pc, 32'h100);

        // Redirect under stall with a response landing in the same cycle.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (inflight.size() > 0) found = 1'b1;
            else applyStimulus(1, 1, 1, 0, 0, 0);
        end
        checkVal("rsp_pending", {31'b0, found}, 32'd1);
        applyStimulus(1, 1, 1, 1, 1, 32'h103);
        checkVal("redir_stall_valid", {31'b0, id_if.valid}, 32'd0);
        checkVal("redir_stall_insn", id_if.instruction, NOP_INSN);
        checkVal("redir_aligned_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, 0, 0);

        // Reset in the middle of a stream.
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkVal("midreset_req", {31'b0, imem_req_valid}, 32'd0);
        checkVal("midreset_valid", {31'b0, id_if.valid}, 32'd0);
        checkVal("midreset_insn", id_if.instruction, NOP_INSN);
        rst = 1'b1; redirect_valid = 1'b0;
        #1;
        checkVal("postreset_req", {31'b0, imem_req_valid}, 32'd1);
        checkVal("postreset_addr", imem_req_addr, RESET_PC);
        applyStimulus(1, 1, 1, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
